// File: rtl/first_nios2_system_sysid_pkg.sv
// Purpose: shared types and constants for the system-ID boot check.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package first_nios2_system_sysid_pkg;

    // Check FSM state. Each encoding bit is one registered output, so the
    // Avalon strobe and the status flags come straight off flops:
    //   bit0 = avm_read / busy, bit1 = avm_address, bit2 = done, bit3 = timeout
    typedef enum logic [3:0] {
        ST_IDLE   = 4'b0000,
        ST_RD_ID  = 4'b0001,
        ST_RD_TS  = 4'b0011,
        ST_FINISH = 4'b0100,
        ST_ABORT  = 4'b1100
    } state_t;

    // Word offsets inside the system-ID slave.
    localparam logic SYSID_OFS_ID = 1'b0;
    localparam logic SYSID_OFS_TS = 1'b1;

    // Build-time defaults for the values the image is expected to carry.
    localparam logic [31:0] DEF_EXPECTED_ID        = 32'h0000_0000;
    localparam logic [31:0] DEF_EXPECTED_TIMESTAMP = 32'h524B_6315;
    localparam int unsigned DEF_TIMEOUT_CYCLES     = 255;

endpackage

// File: rtl/first_nios2_system_sysid_check_if.sv
// Purpose: Avalon-MM read-only link between the sysid checker and the sysid slave.
// Latency: n/a (wires only).
// Backpressure: slave stalls the master with avm_waitrequest.
// Ports: avm_address/avm_read from master, avm_readdata/avm_waitrequest from slave.
interface first_nios2_system_sysid_check_if;
    logic        avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_readdata,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_readdata,
        output avm_waitrequest
    );
endinterface

// File: rtl/first_nios2_system_sysid_stallcnt.sv
// Purpose: counts waitrequest stall cycles of one read and flags the limit.
// Latency: count updates one cycle after enable; hit is a decode of the count.
// Backpressure: none; the count holds at the limit instead of wrapping.
// Ports: clock, reset_n, clear (priority over enable), enable, limit, hit.
module first_nios2_system_sysid_stallcnt #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] limit,
    output logic             hit
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !hit) begin
            count <= count + WIDTH'(1);
        end
    end

    assign hit = (count == limit);

endmodule

// File: rtl/first_nios2_system_sysid_check.sv
// Purpose: reads sysid ID and timestamp words after reset/on start, compares to build values.
// Latency: start at edge N -> read addr 0 in N+1, addr 1 in N+2, done/matches from N+3 (+1 per stall).
// Backpressure: holds address/read while waitrequest=1; aborts after TIMEOUT_CYCLES stalled cycles.
// Ports: clock, reset_n, start; avm (Avalon-MM master modport);
//        status busy/done/timeout/id_match/ts_match; captured id_value/ts_value.
module first_nios2_system_sysid_check
    import first_nios2_system_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = DEF_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TIMESTAMP = DEF_EXPECTED_TIMESTAMP,
    parameter int unsigned TIMEOUT_CYCLES     = DEF_TIMEOUT_CYCLES,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             start,
    first_nios2_system_sysid_check_if.master avm,
    output logic                             busy,
    output logic                             done,
    output logic                             id_match,
    output logic                             ts_match,
    output logic                             timeout,
    output logic [31:0]                      id_value,
    output logic [31:0]                      ts_value
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_t state;
    state_t state_next;
    logic   auto_pend;
    logic   in_read;
    logic   rd_done;
    logic   stall_en;
    logic   stall_hit;
    logic   stall_abort;
    logic   stall_clear;

    assign in_read     = (state == ST_RD_ID) || (state == ST_RD_TS);
    assign rd_done     = in_read && !avm.avm_waitrequest;
    assign stall_en    = in_read && avm.avm_waitrequest;
    // Completion wins over a reached limit; the two are exclusive because a
    // completing cycle has waitrequest low.
    assign stall_abort = stall_en && stall_hit;
    // Clearing on every state change gives each read its own stall budget.
    assign stall_clear = (state_next != state);

    first_nios2_system_sysid_stallcnt #(
        .WIDTH (CW)
    ) u_stallcnt (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (stall_clear),
        .enable  (stall_en),
        .limit   (CW'(TIMEOUT_CYCLES)),
        .hit     (stall_hit)
    );

    // One-shot request that launches the first check after reset release.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            auto_pend <= AUTO_START;
        end else begin
            auto_pend <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start || auto_pend) begin
                    state_next = ST_RD_ID;
                end
            end
            ST_RD_ID: begin
                if (rd_done) begin
                    state_next = ST_RD_TS;
                end else if (stall_abort) begin
                    state_next = ST_ABORT;
                end
            end
            ST_RD_TS: begin
                if (rd_done) begin
                    state_next = ST_FINISH;
                end else if (stall_abort) begin
                    state_next = ST_ABORT;
                end
            end
            ST_FINISH, ST_ABORT: begin
                if (start) begin
                    state_next = ST_RD_ID;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs are individual state bits, so nothing here decodes inputs.
    always_comb begin
        avm.avm_read    = state[0];
        avm.avm_address = state[1] ? SYSID_OFS_TS : SYSID_OFS_ID;
        busy            = state[0];
        done            = state[2];
        timeout         = state[3];
    end

    // Capture registers and match flags. The timestamp compare uses readdata
    // directly so the flags land on the same edge as done.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            id_value <= '0;
            ts_value <= '0;
            id_match <= 1'b0;
            ts_match <= 1'b0;
        end else begin
            if ((state == ST_RD_ID) && rd_done) begin
                id_value <= avm.avm_readdata;
            end
            if ((state == ST_RD_TS) && rd_done) begin
                ts_value <= avm.avm_readdata;
                id_match <= (id_value == EXPECTED_ID);
                ts_match <= (avm.avm_readdata == EXPECTED_TIMESTAMP);
            end
            // A new check or an abort leaves no stale verdict behind.
            if (((state_next == ST_RD_ID) && (state != ST_RD_ID)) ||
                (state_next == ST_ABORT)) begin
                id_match <= 1'b0;
                ts_match <= 1'b0;
            end
        end
    end

endmodule

// File: doc/first_nios2_system_sysid_check.md
# first_nios2_system_sysid_check

Avalon-MM read master that sits directly upstream of the system-ID slave and consumes its readdata. After reset, or on request, it reads the ID word (offset 0) and the timestamp word (offset 1) and compares both against build-time expected values. It publishes pass/fail and timeout status so boot logic can hold the processor or flag a stale FPGA image.

## Interface
Parameters:
- EXPECTED_ID, 32'h0000_0000: expected word at offset 0.
- EXPECTED_TIMESTAMP, 32'h524B_6315 (1380672277): expected word at offset 1.
- TIMEOUT_CYCLES, 255: maximum cycles a single read may stall on waitrequest; range 1..65535.
- AUTO_START, 1: 1 = run one check automatically after reset release.

Ports:
- clock, in, 1: single clock; all logic is rising-edge.
- reset_n, in, 1: asynchronous, active-low reset.
- start, in, 1: one-cycle request to run a check; ignored while busy.
- avm_address, out, 1: word offset; 0 = ID, 1 = timestamp.
- avm_read, out, 1: read strobe.
- avm_readdata, in, 32: slave read data, valid when avm_read=1 and avm_waitrequest=0.
- avm_waitrequest, in, 1: slave stall.
- busy, out, 1: check in progress.
- done, out, 1: last check completed; level signal, held until next start.
- id_match, out, 1: captured ID equals EXPECTED_ID.
- ts_match, out, 1: captured timestamp equals EXPECTED_TIMESTAMP.
- timeout, out, 1: last check aborted on a stall.
- id_value, out, 32: captured ID word.
- ts_value, out, 32: captured timestamp word.

## Operation
- FSM states: IDLE, RD_ID, RD_TS, FINISH, ABORT.
- Reset: state is IDLE; all outputs are 0, including avm_read, avm_address, id_value, and ts_value.
- IDLE: moves to RD_ID when start=1. With AUTO_START=1, a one-shot flag forces this move on the first clock after reset release.
- RD_ID: avm_read=1, avm_address=0.
  - On read & !waitrequest: capture id_value and go to RD_TS.
- RD_TS: avm_read=1, avm_address=1.
  - On read & !waitrequest: capture ts_value and go to FINISH.
- Address and read are held stable while waitrequest=1 (Avalon rule).
- Timeout: a stall counter clears on every state entry and increments each cycle waitrequest=1 in RD_ID or RD_TS.
  - When the count reaches TIMEOUT_CYCLES with waitrequest still 1, go to ABORT.
  - A completion and a reached limit in the same cycle count as completion.
- FINISH: done=1, busy=0.
  - id_match and ts_match are registered 32-bit equality compares of the captured words.
- ABORT: done=1, timeout=1, both match flags=0, avm_read=0. Words already captured are kept.
- start in FINISH or ABORT clears done, timeout, id_match and ts_match, then enters RD_ID.
- start while busy is dropped; it is not queued.
- busy=1 exactly in RD_ID and RD_TS.
- Reset mid-read: avm_read drops asynchronously. AUTO_START re-arms on release.

## Timing
- All outputs are registered; no combinational input-to-output paths.
- start sampled at edge N:
  - avm_read=1 with address 0 during cycle N+1.
  - With zero wait states, address 1 during cycle N+2.
  - done, id_match and ts_match valid from cycle N+3.
- Each waitrequest cycle adds one cycle of latency.
- Worst-case time to ABORT is TIMEOUT_CYCLES+1 cycles after entering a read state.
- avm_read is never deasserted between the two reads when the first completes without stall (back-to-back).

## Structure
- Package first_nios2_system_sysid_pkg holds:
  - State enum.
  - Offset constants SYSID_OFS_ID=1'b0 and SYSID_OFS_TS=1'b1.
  - Default expected values.
- Sub-module first_nios2_system_sysid_stallcnt: clear, enable, limit, and a hit output; width is $clog2(TIMEOUT_CYCLES+1).
- FSM, capture registers and compares live in the top.

## Test plan
- AUTO_START=1, waitrequest=0, slave returns 0 and 1380672277 → done=1 at cycle 3 after reset release; id_match=1, ts_match=1, timeout=0.
- Slave returns timestamp 32'h524B_6316 → ts_match=0, id_match=1, ts_value=32'h524B_6316.
- waitrequest=1 for 3 cycles on each read → address and read stable throughout; done 6 cycles later than the zero-wait case; both match flags=1.
- TIMEOUT_CYCLES=4, waitrequest stuck at 1 → ABORT after 5 cycles in RD_ID; timeout=1, avm_read=0, match flags=0. A later start with waitrequest=0 then passes.
- start pulsed during RD_TS → ignored; exactly two reads occur; then start in FINISH clears flags and reruns.
- reset_n asserted while in RD_TS → avm_read=0 immediately; all outputs 0; with AUTO_START=1 the check restarts after release.
